// File: rtl/conv1d_relu.sv
// Sequential K-tap 1-D convolution with bias, ReLU and output saturation.
// One MAC per clock; emits a single-cycle out_enable pulse per completed result.
module conv1d_relu #(
    parameter int BIT_WIDTH  = 12,
    parameter int K          = 5,
    parameter int COEF_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SHIFT      = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_enable,
    input  logic signed [BIT_WIDTH-1:0]  data_in,
    input  logic                         coef_we,
    input  logic [3:0]                   coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic                         out_enable,
    output logic [BIT_WIDTH-1:0]         data_out,
    output logic                         busy,
    output logic                         overflow
);

    localparam int FILL_W = $clog2(K + 1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                        state, state_nxt;
    logic [3:0]                    tap;
    logic [FILL_W-1:0]             fill;
    logic signed [ACC_WIDTH-1:0]   acc, acc_nxt, prod;
    logic signed [BIT_WIDTH-1:0]   win [K];
    logic signed [COEF_WIDTH-1:0]  coef [K];
    logic signed [COEF_WIDTH-1:0]  bias;
    logic signed [COEF_WIDTH-1:0]  sel_coef;
    logic signed [BIT_WIDTH-1:0]   sel_win;
    logic                          accept, drop, coef_wr, last_tap, win_full;

    // Bias add, floor requantisation, ReLU and clamp to the positive output range.
    function automatic logic [BIT_WIDTH-1:0] relu_sat(
        input logic signed [ACC_WIDTH-1:0]  sum,
        input logic signed [COEF_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH-1:0] y;
        y = sum + (ACC_WIDTH'(b) <<< SHIFT);
        y = y >>> SHIFT;
        if (y[ACC_WIDTH-1])
            return '0;
        else if (y > Y_MAX)
            return Y_MAX[BIT_WIDTH-1:0];
        else
            return y[BIT_WIDTH-1:0];
    endfunction

    assign accept   = in_enable && !clear && (state == S_IDLE);
    assign drop     = in_enable && !clear && (state != S_IDLE);
    assign coef_wr  = coef_we && (state == S_IDLE);
    assign last_tap = (tap == 4'(K - 1));
    assign win_full = (fill >= FILL_W'(K - 1));

    assign busy       = (state != S_IDLE);
    assign out_enable = (state == S_OUT);

    always_comb begin
        sel_coef = '0;
        sel_win  = '0;
        for (int i = 0; i < K; i++) begin
            if (tap == 4'(i)) begin
                sel_coef = coef[i];
                sel_win  = win[i];
            end
        end
        prod    = ACC_WIDTH'(sel_coef) * ACC_WIDTH'(sel_win);
        acc_nxt = acc + prod;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && win_full) state_nxt = S_MAC;
            S_MAC:   if (last_tap) state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (clear) state_nxt = S_IDLE;
    end

    // Control: state, tap counter, fill level, accumulator, sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tap      <= '0;
            fill     <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                tap      <= '0;
                fill     <= '0;
                acc      <= '0;
                overflow <= 1'b0;
            end else begin
                tap <= (state == S_MAC) ? tap + 4'd1 : 4'd0;
                if (state == S_IDLE)
                    acc <= '0;
                else if (state == S_MAC)
                    acc <= acc_nxt;
                if (accept && fill != FILL_W'(K))
                    fill <= fill + FILL_W'(1);
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    // Data: sample window, coefficient bank, result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                win[i]  <= '0;
                coef[i] <= '0;
            end
            bias     <= '0;
            data_out <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < K; i++) win[i] <= '0;
            end else if (accept) begin
                win[0] <= data_in;
                for (int i = 1; i < K; i++) win[i] <= win[i-1];
            end
            if (coef_wr) begin
                for (int i = 0; i < K; i++) begin
                    if (coef_addr == 4'(i)) coef[i] <= coef_data;
                end
                if (coef_addr == 4'(K)) bias <= coef_data;
            end
            // The result is formed on the final MAC edge so it is valid during OUT.
            if (!clear && state == S_MAC && last_tap)
                data_out <= relu_sat(acc_nxt, bias);
        end
    end

endmodule

// File: doc/conv1d_relu.md
# conv1d_relu

Sequential 1-D convolution stage with bias, ReLU and saturation, placed directly upstream of the sequential maxpooling stage in the WVCNN (Gen. 2) datapath. It holds a K-sample sliding window of the input stream and computes one MAC per clock over K cycles per output. It emits a single-cycle `out_enable` pulse with a non-negative, saturated result, in the same pulse-per-sample format the pooling stage consumes. Coefficients and bias are runtime-programmable through a simple write port.

## Interface
- `BIT_WIDTH`, 12: input/output sample width; input is signed, output lies in [0, 2^(BIT_WIDTH-1)-1].
- `K`, 5: number of taps (2..15).
- `COEF_WIDTH`, 8: signed coefficient and bias width.
- `ACC_WIDTH`, 24: signed accumulator width; must be ≥ BIT_WIDTH+COEF_WIDTH+clog2(K)+1.
- `SHIFT`, 6: requantisation right shift; a coefficient of 2^SHIFT equals gain 1.0.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous flush of the window, FSM and overflow flag; coefficients are kept.
- `in_enable`  in  1  single-cycle strobe; `data_in` is valid in this cycle.
- `data_in`  in  BIT_WIDTH  signed input sample.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  4  0..K-1 selects tap i; K selects bias; larger values are ignored.
- `coef_data`  in  COEF_WIDTH  signed write data.
- `out_enable`  out  1  single-cycle strobe; `data_out` is new in this cycle.
- `data_out`  out  BIT_WIDTH  registered result, held until the next output.
- `busy`  out  1  high while state ≠ IDLE.
- `overflow`  out  1  sticky flag: a sample was dropped because it arrived while `busy`.

## Operation
- Window: `win[0..K-1]`, where `win[0]` is the newest sample. An accepted sample shifts in at `win[0]`. `fill` counts accepted samples and saturates at K.
- Result definition: y = Σ coef[i]·win[i] for i=0..K-1, then y += bias<<<SHIFT, then y >>>= SHIFT (arithmetic shift, floor). Then apply ReLU (y<0 gives 0) and clamp to 2^(BIT_WIDTH-1)-1.
- Products are sign-extended to ACC_WIDTH. The accumulator wraps and does not saturate; sizing it correctly is the integrator's responsibility.
- FSM states:
  - IDLE: if `in_enable`, accept the sample and shift it in. If `fill` (including this sample) equals K, go to MAC with tap=0 and acc=0. Otherwise stay in IDLE and produce no output.
  - MAC: each cycle, acc += coef[tap]·win[tap] and tap++. After tap K-1, go to OUT.
  - OUT: register the bias/shift/ReLU/clamp result into `data_out`, pulse `out_enable`, then return to IDLE.
- Samples are accepted only in IDLE. If `in_enable` is high in MAC or OUT, the sample is dropped, `overflow` is set, and the window is unchanged.
- Coefficient writes take effect only in IDLE. Writes while `busy` are ignored, with no flag. A write and an accepted sample in the same IDLE cycle are both performed; the new coefficient is used by the MAC that follows.
- `clear` returns the block to IDLE and clears `fill`, the window, `acc` and `overflow`. It takes precedence over `in_enable` in the same cycle; that sample is discarded and does not set `overflow`. `data_out` holds its value. `out_enable` is 0 in the cycle after `clear`.
- Reset values: `out_enable`=0, `data_out`=0, `busy`=0, `overflow`=0. Window, acc, `fill`, all coefficients and bias are 0. State is IDLE.

## Timing
- Sample accepted at edge t (in cycle t, IDLE). MAC occupies cycles t+1..t+K. OUT is cycle t+K+1, with `out_enable`=1 and the new `data_out` valid. IDLE resumes at t+K+2.
- Latency from the `in_enable` cycle to the `out_enable` cycle is K+1. Minimum lossless input spacing is K+2 cycles.
- `busy` is high in cycles t+1..t+K+1.
- `out_enable` is high for exactly one cycle per completed result. It never fires during warm-up (the first K-1 samples after reset or `clear`).
- Reset asserted mid-MAC aborts immediately. No `out_enable` follows reset release.

## Test plan
- Identity: coef[0]=64, other taps and bias 0; feed 1,2,3,4,5 with spacing 8 → no `out_enable` for samples 1-4; `data_out`=5 exactly 6 cycles after sample 5.
- Moving sum: all taps 64; feed 1..6 → outputs 15 then 20; `overflow` stays 0.
- ReLU, clamp and bias: coef[0]=-64 with input 100 → 0; coef[0]=127 with input 2047 → 2047 (clamped); all taps 0 with bias=3 → 3.
- Overflow: `in_enable` 2 cycles after an accepted sample → `overflow`=1; the following result equals the result without the dropped sample.
- Clear and write gating: `clear` together with `in_enable` → no overflow, `fill`=0, next 4 samples give no output. A `coef_we` while `busy` leaves the current and next results unchanged.
- Reset mid-MAC: assert `rst_n`=0 during cycle t+2 → all outputs 0; K new samples are needed before the next `out_enable`.
